// File: rtl/rf_wr_arb_pkg.sv
// Shared constants for the register-file write-port sequencer/arbiter.
package rf_wr_arb_pkg;

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_RUN   = 1'b1
    } state_e;

    localparam int REG_COUNT = 32;
    localparam int X0_ADDR   = 0;

endpackage

// File: rtl/rf_wr_arb_rr_arbiter.sv
// Combinational round-robin arbiter: first asserted request at or above ptr,
// wrapping modulo N. Produces a one-hot grant plus the winner's index.
module rr_arbiter #(
    parameter int N     = 2,
    parameter int PTR_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     req,
    input  logic [PTR_W-1:0] ptr,
    output logic [N-1:0]     grant,
    output logic [PTR_W-1:0] winner
);

    int   idx;
    logic found;

    always_comb begin
        grant  = '0;
        winner = '0;
        found  = 1'b0;
        idx    = 0;
        for (int i = 0; i < N; i++) begin
            idx = (int'(ptr) + i) % N;
            if (!found && req[idx]) begin
                found      = 1'b1;
                grant[idx] = 1'b1;
                winner     = PTR_W'(idx);
            end
        end
    end

endmodule

// File: rtl/rf_wr_arb.sv
// Register-file write-port owner: zero-clears x1..x31 after reset, then
// round-robins the port between writeback sources with registered outputs.
module rf_wr_arb
    import rf_wr_arb_pkg::*;
#(
    parameter int NUM_REQ        = 2,
    parameter int ADDR_W         = 5,
    parameter int DATA_W         = 32,
    parameter int CLEAR_ON_RESET = 1
) (
    input  logic                      rf_wr_arb_clk,
    input  logic                      rf_wr_arb_rst,
    input  logic [NUM_REQ-1:0]        rf_wr_arb_req_valid,
    input  logic [NUM_REQ*ADDR_W-1:0] rf_wr_arb_req_addr,
    input  logic [NUM_REQ*DATA_W-1:0] rf_wr_arb_req_data,
    output logic [NUM_REQ-1:0]        rf_wr_arb_req_ready,
    output logic                      rf_wr_arb_RegWrite,
    output logic [ADDR_W-1:0]         rf_wr_arb_WriteReg,
    output logic [DATA_W-1:0]         rf_wr_arb_WriteData,
    output logic                      rf_wr_arb_busy
);

    localparam int     PTR_W     = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam state_e RST_STATE = (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_RUN;

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   clr_idx_q, clr_idx_d;
    logic [PTR_W-1:0]    rr_ptr_q, rr_ptr_d;
    logic                regwrite_q, regwrite_d;
    logic [ADDR_W-1:0]   writereg_q, writereg_d;
    logic [DATA_W-1:0]   writedata_q, writedata_d;

    logic [NUM_REQ-1:0]  grant;
    logic [PTR_W-1:0]    winner;
    logic [ADDR_W-1:0]   win_addr;
    logic [DATA_W-1:0]   win_data;

    rr_arbiter #(.N(NUM_REQ), .PTR_W(PTR_W)) u_arb (
        .req    (rf_wr_arb_req_valid),
        .ptr    (rr_ptr_q),
        .grant  (grant),
        .winner (winner)
    );

    assign win_addr = rf_wr_arb_req_addr[int'(winner)*ADDR_W +: ADDR_W];
    assign win_data = rf_wr_arb_req_data[int'(winner)*DATA_W +: DATA_W];

    always_comb begin
        state_d             = state_q;
        clr_idx_d           = clr_idx_q;
        rr_ptr_d            = rr_ptr_q;
        regwrite_d          = 1'b0;
        writereg_d          = writereg_q;
        writedata_d         = writedata_q;
        rf_wr_arb_req_ready = '0;
        case (state_q)
            ST_CLEAR: begin
                regwrite_d  = 1'b1;
                writereg_d  = clr_idx_q;
                writedata_d = '0;
                clr_idx_d   = clr_idx_q + ADDR_W'(1);
                if (clr_idx_q == ADDR_W'(REG_COUNT - 1))
                    state_d = ST_RUN;
            end
            ST_RUN: begin
                rf_wr_arb_req_ready = grant;
                if (|grant) begin
                    rr_ptr_d = PTR_W'((int'(winner) + 1) % NUM_REQ);
                    // x0 is hardwired: accept the handshake but drop the write
                    if (win_addr != ADDR_W'(X0_ADDR)) begin
                        regwrite_d  = 1'b1;
                        writereg_d  = win_addr;
                        writedata_d = win_data;
                    end
                end
            end
            default: state_d = RST_STATE;
        endcase
    end

    always_ff @(posedge rf_wr_arb_clk or negedge rf_wr_arb_rst) begin
        if (!rf_wr_arb_rst) begin
            state_q     <= RST_STATE;
            clr_idx_q   <= ADDR_W'(1);
            rr_ptr_q    <= '0;
            regwrite_q  <= 1'b0;
            writereg_q  <= '0;
            writedata_q <= '0;
        end else begin
            state_q     <= state_d;
            clr_idx_q   <= clr_idx_d;
            rr_ptr_q    <= rr_ptr_d;
            regwrite_q  <= regwrite_d;
            writereg_q  <= writereg_d;
            writedata_q <= writedata_d;
        end
    end

    assign rf_wr_arb_RegWrite  = regwrite_q;
    assign rf_wr_arb_WriteReg  = writereg_q;
    assign rf_wr_arb_WriteData = writedata_q;
    assign rf_wr_arb_busy      = (state_q == ST_CLEAR);

endmodule
